// File: rtl/nibble_xcheck_fifo_if.sv
// Handshake bundle for nibble_xcheck_fifo: 4-state capture side, valid/ready drain side, status flags.
interface nibble_xcheck_fifo_if #(
    parameter int DW    = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DW-1:0]    in_data;
    logic             in_en;
    logic             clear_err;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;
    logic             xz_err;
    logic             ovf;
    logic [CNT_W-1:0] xz_cnt;

    modport master (
        output in_data, in_en, clear_err, out_ready,
        input  out_valid, out_data, level, full, empty, xz_err, ovf, xz_cnt
    );

    modport slave (
        input  in_data, in_en, clear_err, out_ready,
        output out_valid, out_data, level, full, empty, xz_err, ovf, xz_cnt
    );
endinterface

// File: rtl/nibble_xcheck_fifo.sv
// Samples a possibly-unknown nibble bus, buffers clean enabled nibbles in a small FIFO,
// and counts/flags X/Z events without letting unknowns reach any state or output.
module nibble_xcheck_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    nibble_xcheck_fifo_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    level_q;
    logic             xz_err_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic en_one;
    logic en_zero;
    logic data_xz;
    logic push_req;
    logic xz_evt;
    logic is_full;
    logic is_empty;
    logic pop;
    logic push;
    logic drop;

    // v ^ v is 0 for every known bit and X for every X/Z bit, so this folds to 0 in hardware.
    function automatic logic has_xz(input logic [DW-1:0] v);
        return (v ^ v) !== '0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign en_one   = (bus.in_en === 1'b1);
    assign en_zero  = (bus.in_en === 1'b0);
    assign data_xz  = has_xz(bus.in_data);
    assign push_req = en_one && !data_xz;
    assign xz_evt   = (!en_one && !en_zero) || (en_one && data_xz);

    assign is_full  = (level_q == LW'(DEPTH));
    assign is_empty = (level_q == '0);
    assign pop      = !is_empty && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!is_full || pop);
    assign drop     = push_req && is_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            level_q  <= '0;
            xz_err_q <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);

            // A same-cycle event wins over clear_err, so the event is never lost.
            xz_err_q <= xz_evt | (xz_err_q & !bus.clear_err);
            ovf_q    <= drop   | (ovf_q    & !bus.clear_err);
            if (bus.clear_err)  cnt_q <= xz_evt ? CNT_W'(1) : '0;
            else if (xz_evt)    cnt_q <= sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.in_data;
    end

    assign bus.out_valid = !is_empty;
    assign bus.out_data  = is_empty ? '0 : mem[rptr];
    assign bus.level     = level_q;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.xz_err    = xz_err_q;
    assign bus.ovf       = ovf_q;
    assign bus.xz_cnt    = cnt_q;
endmodule

// File: tb/tb_nibble_xcheck_fifo.sv
// Directed bench for nibble_xcheck_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_nibble_xcheck_fifo;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    bit   check_on;
    bit   four_state;
    logic probe;
    int   tests;
    int   fails;

    nibble_xcheck_fifo_if #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    nibble_xcheck_fifo #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a queue of stored nibbles plus the three flags.
    logic [DW-1:0] mq[$];
    bit            m_err;
    bit            m_ovf;
    int            m_cnt;

    task automatic model_reset();
        mq.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_step();
        bit evt, req, pop, was_full;
        evt      = $isunknown(bus.in_en) || (bus.in_en === 1'b1 && $isunknown(bus.in_data));
        req      = (bus.in_en === 1'b1) && !$isunknown(bus.in_data);
        pop      = (mq.size() != 0) && (bus.out_ready === 1'b1);
        was_full = (mq.size() == DEPTH);
        if (bus.clear_err === 1'b1) begin
            m_err = 1'b0;
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (evt) begin
            m_err = 1'b1;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
        if (pop) void'(mq.pop_front());
        if (req) begin
            if (!was_full || pop) mq.push_back(bus.in_data);
            else                  m_ovf = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (check_on) begin
                cmp("m_out_valid", 32'(bus.out_valid), int'(mq.size() != 0));
                cmp("m_out_data",  32'(bus.out_data),  (mq.size() != 0) ? int'(mq[0]) : 0);
                cmp("m_level",     32'(bus.level),     mq.size());
                cmp("m_full",      32'(bus.full),      int'(mq.size() == DEPTH));
                cmp("m_empty",     32'(bus.empty),     int'(mq.size() == 0));
                cmp("m_xz_err",    32'(bus.xz_err),    int'(m_err));
                cmp("m_ovf",       32'(bus.ovf),       int'(m_ovf));
                cmp("m_xz_cnt",    32'(bus.xz_cnt),    m_cnt);
            end
        end
    end

    task automatic cyc(input logic [DW-1:0] d, input logic en, input logic rdy, input logic clr);
        bus.in_data   = d;
        bus.in_en     = en;
        bus.out_ready = rdy;
        bus.clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        probe = 1'bx;
        four_state = $isunknown(probe);
        rst_n = 1'b1;
        bus.in_data = '0;
        bus.in_en = 1'b0;
        bus.out_ready = 1'b0;
        bus.clear_err = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle with unknown data and enable low
        cyc(4'bxxxx, 1'b0, 1'b0, 1'b0);
        cyc(4'bxxxx, 1'b0, 1'b0, 1'b0);
        cmp("idle_valid", 32'(bus.out_valid), 0);
        cmp("idle_empty", 32'(bus.empty), 1);
        cmp("idle_data",  32'(bus.out_data), 0);
        cmp("idle_cnt",   32'(bus.xz_cnt), 0);
        cmp("idle_err",   32'(bus.xz_err), 0);

        // Single push, then pop
        cyc(4'hB, 1'b1, 1'b0, 1'b0);
        cmp("push_valid", 32'(bus.out_valid), 1);
        cmp("push_data",  32'(bus.out_data), 'hB);
        cmp("push_level", 32'(bus.level), 1);
        cyc(4'h0, 1'b0, 1'b1, 1'b0);
        cmp("pop_empty",  32'(bus.empty), 1);

        // Fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) cyc(DW'(i), 1'b1, 1'b0, 1'b0);
        cmp("fill_full",  32'(bus.full), 1);
        cyc(4'h5, 1'b1, 1'b0, 1'b0);
        cmp("ovf_flag",   32'(bus.ovf), 1);
        cmp("ovf_level",  32'(bus.level), 4);
        for (int i = 1; i <= 4; i++) begin
            cmp("drain_order", 32'(bus.out_data), i);
            cyc(4'h0, 1'b0, 1'b1, 1'b0);
        end
        cmp("drain_empty", 32'(bus.empty), 1);

        // Push into full FIFO while popping
        cyc(4'h0, 1'b0, 1'b0, 1'b1);
        cmp("clr_ovf", 32'(bus.ovf), 0);
        for (int i = 1; i <= 4; i++) cyc(DW'(i), 1'b1, 1'b0, 1'b0);
        cyc(4'h6, 1'b1, 1'b1, 1'b0);
        cmp("fullpp_level", 32'(bus.level), 4);
        cmp("fullpp_head",  32'(bus.out_data), 2);
        cmp("fullpp_ovf",   32'(bus.ovf), 0);
        begin
            logic [DW-1:0] exp_order [4];
            exp_order = '{4'h2, 4'h3, 4'h4, 4'h6};
            for (int i = 0; i < 4; i++) begin
                cmp("fullpp_order", 32'(bus.out_data), int'(exp_order[i]));
                cyc(4'h0, 1'b0, 1'b1, 1'b0);
            end
        end

        // Asynchronous reset mid-operation
        cyc(4'h7, 1'b1, 1'b0, 1'b0);
        cyc(4'h8, 1'b1, 1'b0, 1'b0);
        cmp("pre_rst_level", 32'(bus.level), 2);
        #2 rst_n = 1'b0;
        #1;
        cmp("rst_empty", 32'(bus.empty), 1);
        cmp("rst_valid", 32'(bus.out_valid), 0);
        cmp("rst_data",  32'(bus.out_data), 0);
        bus.in_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4'hA, 1'b1, 1'b0, 1'b0);
        cmp("post_rst_data",  32'(bus.out_data), 'hA);
        cmp("post_rst_level", 32'(bus.level), 1);
        cyc(4'h0, 1'b0, 1'b1, 1'b0);

        // X/Z events (observable only on a 4-state simulator)
        cyc(4'b10x1, 1'b1, 1'b0, 1'b0);
        if (four_state) begin
            cmp("xdata_err",   32'(bus.xz_err), 1);
            cmp("xdata_cnt",   32'(bus.xz_cnt), 1);
            cmp("xdata_level", 32'(bus.level), 0);
        end
        cyc(4'h3, 1'bx, 1'b0, 1'b0);
        if (four_state) begin
            cmp("xen_cnt",   32'(bus.xz_cnt), 2);
            cmp("xen_level", 32'(bus.level), 0);
        end
        repeat (300) cyc(4'bxxxx, 1'b1, 1'b1, 1'b0);
        if (four_state) cmp("sat_cnt", 32'(bus.xz_cnt), CMAX);
        cyc(4'bx000, 1'b1, 1'b1, 1'b1);
        if (four_state) begin
            cmp("clr_evt_cnt", 32'(bus.xz_cnt), 1);
            cmp("clr_evt_err", 32'(bus.xz_err), 1);
        end

        // Plain clear, then clear coinciding with an overflow
        repeat (5) cyc(4'h0, 1'b0, 1'b1, 1'b0);
        cyc(4'h0, 1'b0, 1'b0, 1'b1);
        cmp("clr_cnt", 32'(bus.xz_cnt), 0);
        cmp("clr_err", 32'(bus.xz_err), 0);
        for (int i = 1; i <= 4; i++) cyc(DW'(i), 1'b1, 1'b0, 1'b0);
        cyc(4'h9, 1'b1, 1'b0, 1'b1);
        cmp("clr_ovf_same", 32'(bus.ovf), 1);
        cmp("clr_ovf_level", 32'(bus.level), 4);
        cmp("clr_ovf_head", 32'(bus.out_data), 1);

        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
